// File: rtl/fp16_to_fixed_if.sv
// Handshake bundle for the binary16 -> unsigned fixed-point converter.
// Input side: operand offer. Output side: result plus per-result status flags.
interface fp16_to_fixed_if #(parameter int OUT_W = 16);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      float_in;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] fixed_out;
  logic             flag_ovf;
  logic             flag_neg;
  logic             flag_nan;
  logic             flag_inexact;

  modport master (
    output in_valid, float_in, out_ready,
    input  in_ready, out_valid, fixed_out, flag_ovf, flag_neg, flag_nan, flag_inexact
  );

  modport slave (
    input  in_valid, float_in, out_ready,
    output in_ready, out_valid, fixed_out, flag_ovf, flag_neg, flag_nan, flag_inexact
  );
endinterface

// File: rtl/fp16_to_fixed.sv
// Two-stage binary16 -> unsigned fixed-point converter, truncating toward zero.
// Stage 1 classifies and forms significand/shift; stage 2 shifts, saturates and flags.
module fp16_to_fixed #(
  parameter int OUT_W     = 16,
  parameter int FRAC_BITS = 0
) (
  input logic              clk,
  input logic              rst_n,
  fp16_to_fixed_if.slave   bus
);

  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_FIN  = 3'd1,
    CLS_INF  = 3'd2,
    CLS_NAN  = 3'd3,
    CLS_NEG  = 3'd4
  } cls_e;

  // Largest left shift that still fits an 11-bit significand in OUT_W bits.
  localparam logic signed [7:0] OVF_K = 8'(OUT_W - 11);
  // k = E - 10 + FRAC_BITS with E = biased_exp - 15 collapses to biased_exp + K_OFS.
  localparam logic signed [7:0] K_OFS = 8'(FRAC_BITS - 25);

  logic                    w_s1_adv;
  logic                    w_s2_adv;
  logic                    r_s1_valid;
  logic                    r_s2_valid;
  cls_e                    r_s1_cls;
  cls_e                    w_cls;
  logic [10:0]             r_s1_sig;
  logic [10:0]             w_sig;
  logic signed [7:0]       r_s1_k;
  logic signed [7:0]       w_k;
  logic [4:0]              w_exp;
  logic [9:0]              w_man;
  logic [7:0]              w_nshift;
  logic [10:0]             w_mask;
  logic [OUT_W-1:0]        w_sig_ext;
  logic [OUT_W-1:0]        w_res;
  logic                    w_ovf;
  logic                    w_neg;
  logic                    w_nan;
  logic                    w_inx;
  logic [OUT_W-1:0]        r_fixed;
  logic                    r_ovf;
  logic                    r_neg;
  logic                    r_nan;
  logic                    r_inx;

  assign w_s2_adv         = !r_s2_valid || bus.out_ready;
  assign w_s1_adv         = !r_s1_valid || w_s2_adv;
  assign bus.in_ready     = w_s1_adv;
  assign bus.out_valid    = r_s2_valid;
  assign bus.fixed_out    = r_fixed;
  assign bus.flag_ovf     = r_ovf;
  assign bus.flag_neg     = r_neg;
  assign bus.flag_nan     = r_nan;
  assign bus.flag_inexact = r_inx;

  // Operand decode: class priority NaN > negative nonzero > +Inf > zero > finite.
  always_comb begin
    w_exp = bus.float_in[14:10];
    w_man = bus.float_in[9:0];
    w_sig = {(w_exp != 5'd0), w_man};
    w_k   = (w_exp == 5'd0) ? (8'sd1 + K_OFS) : ($signed({3'b000, w_exp}) + K_OFS);
    if ((w_exp == 5'd31) && (w_man != 10'd0)) begin
      w_cls = CLS_NAN;
    end else if (bus.float_in[15] && ((w_exp != 5'd0) || (w_man != 10'd0))) begin
      w_cls = CLS_NEG;
    end else if (w_exp == 5'd31) begin
      w_cls = CLS_INF;
    end else if ((w_exp == 5'd0) && (w_man == 10'd0)) begin
      w_cls = CLS_ZERO;
    end else begin
      w_cls = CLS_FIN;
    end
  end

  // Stage 1 register: loads whenever the slot is free or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_cls   <= CLS_ZERO;
      r_s1_sig   <= 11'd0;
      r_s1_k     <= 8'sd0;
    end else if (w_s1_adv) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_cls <= w_cls;
        r_s1_sig <= w_sig;
        r_s1_k   <= w_k;
      end else begin
        r_s1_cls <= r_s1_cls;
      end
    end else begin
      r_s1_valid <= r_s1_valid;
    end
  end

  // Shift/saturate: right shifts of 11 or more leave nothing but the sticky bit.
  always_comb begin
    w_res     = '0;
    w_ovf     = 1'b0;
    w_neg     = 1'b0;
    w_nan     = 1'b0;
    w_inx     = 1'b0;
    w_nshift  = 8'(-r_s1_k);
    w_mask    = (11'd1 << w_nshift[3:0]) - 11'd1;
    w_sig_ext = OUT_W'(r_s1_sig);
    case (r_s1_cls)
      CLS_NAN:  w_nan = 1'b1;
      CLS_NEG:  w_neg = 1'b1;
      CLS_INF: begin
        w_res = '1;
        w_ovf = 1'b1;
      end
      CLS_ZERO: w_res = '0;
      CLS_FIN: begin
        if (!r_s1_k[7]) begin
          if (r_s1_k > OVF_K) begin
            w_res = '1;
            w_ovf = 1'b1;
          end else begin
            w_res = w_sig_ext << r_s1_k[5:0];
          end
        end else if (w_nshift >= 8'd11) begin
          w_inx = (r_s1_sig != 11'd0);
        end else begin
          w_res = OUT_W'(r_s1_sig >> w_nshift[3:0]);
          w_inx = |(r_s1_sig & w_mask);
        end
      end
      default:  w_res = '0;
    endcase
  end

  // Stage 2 / output register: holds result and flags while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_fixed    <= '0;
      r_ovf      <= 1'b0;
      r_neg      <= 1'b0;
      r_nan      <= 1'b0;
      r_inx      <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_fixed <= w_res;
        r_ovf   <= w_ovf;
        r_neg   <= w_neg;
        r_nan   <= w_nan;
        r_inx   <= w_inx;
      end else begin
        r_fixed <= r_fixed;
      end
    end else begin
      r_s2_valid <= r_s2_valid;
    end
  end

endmodule

// File: tb/tb_fp16_to_fixed.sv
// Bench for fp16_to_fixed: two instances (FRAC_BITS=0 and 4) driven in lockstep,
// checked against an arithmetic reference model through per-instance scoreboards.
module tb_fp16_to_fixed;
  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   chk_lat  = 1'b0;

  logic [19:0] q0[$];
  logic [19:0] q4[$];
  int          cq0[$];
  logic [15:0] stim_q[$];

  fp16_to_fixed_if #(.OUT_W(16)) if0 ();
  fp16_to_fixed_if #(.OUT_W(16)) if4 ();

  fp16_to_fixed #(.OUT_W(16), .FRAC_BITS(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  fp16_to_fixed #(.OUT_W(16), .FRAC_BITS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: value = sig * 2^(E-10+frac), truncated; packed {ovf,neg,nan,inx,value}.
  function automatic logic [19:0] model(input logic [15:0] f, input int frac);
    int     e;
    int     m;
    int     p;
    longint sig;
    longint v;
    longint d;
    logic   inx;
    e = int'(f[14:10]);
    m = int'(f[9:0]);
    if (e == 31 && m != 0) return {4'b0010, 16'h0000};
    if (f[15] && (e != 0 || m != 0)) return {4'b0100, 16'h0000};
    if (e == 31) return {4'b1000, 16'hFFFF};
    if (e == 0 && m == 0) return 20'h0;
    sig = (e == 0) ? longint'(m) : longint'(m + 1024);
    p   = ((e == 0) ? -14 : e - 15) - 10 + frac;
    if (p >= 0) begin
      v = sig * (longint'(1) << p);
      if (v > 65535) return {4'b1000, 16'hFFFF};
      return {4'b0000, v[15:0]};
    end
    d   = longint'(1) << (-p);
    v   = sig / d;
    inx = ((sig % d) != 0);
    return {3'b000, inx, v[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [15:0] f, input logic r);
    if0.in_valid = v;  if4.in_valid = v;
    if0.float_in = f;  if4.float_in = f;
    if0.out_ready = r; if4.out_ready = r;
  endtask

  task automatic score(input int which, input logic [19:0] obs);
    logic [19:0] e;
    int          c;
    bit          have;
    c = 0;
    e = 20'h0;
    if (which == 0) begin
      have = (q0.size() > 0);
      if (have) begin e = q0.pop_front(); c = cq0.pop_front(); end
    end else begin
      have = (q4.size() > 0);
      if (have) e = q4.pop_front();
    end
    chk($sformatf("expected_pending_d%0d", which), 32'(have), 32'd1);
    if (have) begin
      chk($sformatf("fixed_out_d%0d", which), 32'(obs[15:0]), 32'(e[15:0]));
      chk($sformatf("flags_d%0d", which), 32'(obs[19:16]), 32'(e[19:16]));
      if (which == 0 && chk_lat) chk("latency", 32'(cyc - c), 32'd2);
    end
  endtask

  // One clock: score outputs transferring and record operands accepted at the next edge.
  task automatic cycle(output bit acc);
    #1;
    acc = if0.in_valid && if0.in_ready;
    if (if0.out_valid && if0.out_ready)
      score(0, {if0.flag_ovf, if0.flag_neg, if0.flag_nan, if0.flag_inexact, if0.fixed_out});
    if (if4.out_valid && if4.out_ready)
      score(4, {if4.flag_ovf, if4.flag_neg, if4.flag_nan, if4.flag_inexact, if4.fixed_out});
    if (acc) begin
      q0.push_back(model(if0.float_in, 0));
      q4.push_back(model(if4.float_in, 4));
      cq0.push_back(cyc);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send_list(input int valid_pct, input int rdy_pct);
    int idx;
    int budget;
    bit acc;
    bit v;
    idx    = 0;
    budget = 0;
    while ((idx < stim_q.size() || q0.size() > 0 || q4.size() > 0) && budget < 5000) begin
      v = (idx < stim_q.size()) && ($urandom_range(99) < valid_pct);
      set_in(v, v ? stim_q[idx] : 16'h0000, $urandom_range(99) < rdy_pct);
      cycle(acc);
      if (acc) idx++;
      budget++;
    end
    chk("stream_completes", 32'(budget < 5000), 32'd1);
    set_in(1'b0, 16'h0000, 1'b1);
    stim_q.delete();
  endtask

  initial begin
    bit          acc;
    int          idx;
    logic [15:0] f;
    logic [15:0] bp_ops[4];
    bp_ops = '{16'h3C00, 16'h4A40, 16'h6400, 16'h7C00};

    rst_n = 1'b0;
    set_in(1'b0, 16'h0000, 1'b1);
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(if0.out_valid), 32'd0);
    chk("reset_fixed_out", 32'(if0.fixed_out), 32'd0);
    chk("reset_flags", 32'({if0.flag_ovf, if0.flag_neg, if0.flag_nan, if0.flag_inexact}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back stream with 2-cycle latency.
    chk_lat = 1'b1;
    stim_q = '{16'h3C00, 16'h6400, 16'h7BFF, 16'h0000, 16'h8000};
    send_list(100, 100);
    chk_lat = 1'b0;

    // Truncation, specials, FRAC_BITS=4 cases on the second instance.
    stim_q = '{16'h4A40, 16'h3800, 16'h0001, 16'h7C00, 16'hFC00, 16'h7E00,
               16'hBC00, 16'h3400, 16'h7BFF, 16'h83FF, 16'hFE01, 16'h5BFF};
    send_list(100, 100);

    // Backpressure: two accepts fill the pipe, head result holds.
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, bp_ops[idx], 1'b0);
      cycle(acc);
      if (acc) idx++;
    end
    chk("bp_accepts", 32'(idx), 32'd2);
    chk("bp_in_ready_low", 32'(if0.in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cycle(acc);
      chk("bp_hold_valid", 32'(if0.out_valid), 32'd1);
      chk("bp_hold_value", 32'(if0.fixed_out), 32'(model(bp_ops[0], 0) & 20'hFFFF));
    end
    set_in(1'b1, bp_ops[idx], 1'b1);
    #1;
    chk("bp_in_ready_release", 32'(if0.in_ready), 32'd1);
    while (idx < 4) begin
      set_in(1'b1, bp_ops[idx], 1'b1);
      cycle(acc);
      if (acc) idx++;
    end
    send_list(100, 100);

    // Random operands under random valid gaps and backpressure.
    for (int i = 0; i < 300; i++) begin
      f = 16'($urandom);
      if ($urandom_range(3) != 0) f[15] = 1'b0;
      if ($urandom_range(1) == 1) f[14:10] = 5'($urandom_range(30, 5));
      stim_q.push_back(f);
    end
    send_list(80, 60);

    // Reset with both stages full.
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, (i == 0) ? 16'h7BFF : 16'h6400, 1'b0);
      cycle(acc);
    end
    set_in(1'b0, 16'h0000, 1'b0);
    chk("pre_reset_full", 32'(if0.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", 32'(if0.out_valid), 32'd0);
    chk("async_reset_fixed_out", 32'(if0.fixed_out), 32'd0);
    chk("async_reset_out_valid_d4", 32'(if4.out_valid), 32'd0);
    q0.delete(); q4.delete(); cq0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1'b0, 16'h0000, 1'b1);
    #1;
    chk("post_reset_in_ready", 32'(if0.in_ready), 32'd1);
    @(negedge clk);
    stim_q = '{16'h3C00, 16'h4A40};
    send_list(100, 100);
    for (int i = 0; i < 4; i++) cycle(acc);

    chk("scoreboard_empty", 32'(q0.size() + q4.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
